ll_mac_bridge: RTL and testbench
================================

# ll_mac_bridge

Synthesizable bridge between a byte/word-stream MAC (valid/error strobes) and the active-low LocalLink interface of `ethernetController`. It generalises the simulation-only RX framing and TX packet spacing logic in several ways:

- parametrised data width and pipeline depth;
- an EOF aligned to the last data beat;
- oversize/error frame dropping;
- a configurable inter-frame gap;
- TX underrun detection and frame statistics.

It sits between the MAC core (or PLI model) and the controller, in the controller clock domain.

## Interface
- DATA_WIDTH, 8: data bits per beat on both sides.
- RX_PIPE_STAGES, 1: extra register stages on the RX LocalLink outputs (0–4).
- IFG_CYCLES, 4: minimum idle cycles between TX frames (1–255).
- MAX_FRAME_BEATS, 1518: longest accepted RX frame, in beats.
- CNT_WIDTH, 16: width of the statistics counters.
- clock  in  1  sole clock.
- reset  in  1  synchronous, active-high.
- mac_rx_data  in  DATA_WIDTH  RX beat from the MAC.
- mac_rx_valid  in  1  high while the frame is in progress; one beat per cycle.
- mac_rx_error  in  1  MAC error on the current beat.
- rx_ll_data  out  DATA_WIDTH  LocalLink RX data.
- rx_ll_sof_n / rx_ll_eof_n / rx_ll_src_rdy_n  out  1 each  active low.
- tx_ll_data  in  DATA_WIDTH  LocalLink TX data.
- tx_ll_sof_n / tx_ll_eof_n / tx_ll_src_rdy_n  in  1 each  active low.
- tx_ll_dst_rdy_n  out  1  active low; the bridge accepts TX beats.
- mac_tx_data  out  DATA_WIDTH  TX beat to the MAC.
- mac_tx_en  out  1  mac_tx_data valid.
- mac_tx_error  out  1  underrun; the MAC must abort the frame.
- rx_frame_count / rx_drop_count / tx_frame_count  out  CNT_WIDTH each  saturating counters.

## Operation
- **RX FSM states:** RX_IDLE, RX_RECV, RX_DISCARD.
  - A one-beat hold register delays each beat until its successor arrives or valid falls, so EOF marks the true last beat.
- **RX_IDLE:** valid=1 loads hold, sets the first flag, clears the beat count → RX_RECV.
- **RX_RECV, valid=1:** emit the held beat (sof_n=0 if first), load the new beat, count++.
- **RX_RECV, valid=0:** emit the held beat with eof_n=0 (sof_n=0 too if it is a 1-beat frame); rx_frame_count++ → RX_IDLE.
- **Error in RX_RECV** (mac_rx_error=1, or count would exceed MAX_FRAME_BEATS): emit the held beat with eof_n=0 if any beat has already been emitted, else emit nothing. rx_drop_count++; the new beat is not loaded → RX_DISCARD.
- **RX_DISCARD:** ignore input until valid=0 → RX_IDLE.
- **Error on the first beat** (in RX_IDLE): drop, count it, go to RX_DISCARD.
- **TX FSM states:** TX_IDLE, TX_FRAME, TX_GAP.
  - **TX_IDLE / TX_FRAME:** dst_rdy_n=0.
  - **Accepted beat:** dst_rdy_n=0 and src_rdy_n=0 in the same cycle. Each accepted beat is driven to the MAC.
  - **TX_IDLE:** an accepted beat with sof_n=0 → TX_FRAME. Beats without sof are discarded.
  - **TX_FRAME:** an accepted eof → tx_frame_count++, load the gap counter with IFG_CYCLES → TX_GAP.
  - **TX_FRAME, src_rdy_n=1 (underrun):** pulse mac_tx_error for 1 cycle and go to TX_GAP. The rest of the frame is dropped by TX_IDLE's no-sof rule.
  - **TX_GAP:** dst_rdy_n=1; decrement the gap counter; at 0 → TX_IDLE.
- **Counters** saturate at all-ones.
- **Reset:** both FSMs go to IDLE, the pipelines are flushed, the counters clear.

## Timing
- Reset values:
  - all *_n outputs 1, except tx_ll_dst_rdy_n=0;
  - mac_tx_en=0 and mac_tx_error=0;
  - data outputs 0;
  - counters 0.
- **RX latency:** a beat at the MAC input in cycle t appears on LocalLink in cycle t+2+RX_PIPE_STAGES (hold register plus output register).
- **RX EOF:** the last beat appears 2+RX_PIPE_STAGES cycles after its arrival, i.e. one cycle after valid falls plus the pipe stages.
- **TX latency:** registered, 1 cycle from acceptance to mac_tx_en=1.
- **TX gap:**
  - dst_rdy_n goes 1 in the cycle after EOF acceptance and stays 1 for exactly IFG_CYCLES cycles.
  - The MAC therefore sees ≥ IFG_CYCLES idle cycles between frames.
- **Back-to-back RX frames:** valid low for a single cycle between frames is legal. The new frame's first beat loads hold in the same cycle the previous frame's EOF beat is emitted.
- **Reset mid-frame:** the partial frame is discarded and no EOF is generated. Any frame already partly on LocalLink is the controller's to abort on reset.

## Structure
- Package `ll_mac_bridge_pkg`: RX/TX state enums, the saturating-increment function, and the active-low LocalLink constants.
- One sub-module, `ll_pipe_delay`: parametrised DATA_WIDTH+3 bit, depth RX_PIPE_STAGES register chain with synchronous reset. Depth 0 is a pass-through.

## Test plan
- **Single 64-beat frame, bytes 0x00..0x3F:**
  - sof on 0x00 at cycle t0+3, eof on 0x3F at t0+66;
  - src_rdy_n low for 64 contiguous cycles;
  - rx_frame_count=1.
- **1-beat frame 0xA5:** sof_n=eof_n=0 on the same beat; frames with a 1-cycle valid gap both delivered intact.
- **Errors:**
  - rx_error on beat 10 of 20: LocalLink gets 9 beats, the last with eof; rx_drop_count=1.
  - Frame of MAX_FRAME_BEATS+1: truncated at MAX_FRAME_BEATS beats with eof; drop counted.
- **TX, two 16-beat frames offered back-to-back with IFG_CYCLES=4:** mac_tx_en shows 16 high, ≥4 low, 16 high; tx_frame_count=2.
- **TX underrun:** src_rdy_n high at beat 5 → mac_tx_error 1-cycle pulse, gap enforced, following frame transmitted normally.
- **Reset:**
  - asserted mid-RX and mid-TX: all outputs return to their reset values the next cycle, counters 0;
  - the next frame after reset is received correctly.

Source files
------------

// File: rtl/ll_mac_bridge_pkg.sv
// Shared types and helpers for ll_mac_bridge.
// Contents:
//   - RX/TX FSM state enums
//   - active-low LocalLink level constants
//   - sat_inc(): saturating increment for statistics counters up to 32 bits wide
package ll_mac_bridge_pkg;

  typedef enum logic [1:0] {
    RxIdle,
    RxRecv,
    RxDiscard
  } rx_state_e;

  typedef enum logic [1:0] {
    TxIdle,
    TxFrame,
    TxGap
  } tx_state_e;

  // LocalLink strobes are active low.
  localparam logic LlAssert   = 1'b0;
  localparam logic LlDeassert = 1'b1;

  // Increment val, sticking at the all-ones value of a width-bit counter.
  function automatic logic [31:0] sat_inc(input logic [31:0] val, input int unsigned width);
    logic [31:0] max_val;
    max_val = (width >= 32) ? 32'hFFFF_FFFF : ((32'd1 << width) - 32'd1);
    return (val >= max_val) ? max_val : val + 32'd1;
  endfunction

endpackage

// File: rtl/ll_mac_bridge_if.sv
// Bundle of the MAC-side and LocalLink-side signals of ll_mac_bridge.
// Modports:
//   master - the bridge: consumes MAC RX beats and LocalLink TX beats, drives LocalLink RX,
//            the MAC TX beat, TX destination-ready and the statistics counters.
//   slave  - the environment (MAC core / controller) on the other side of every signal.
interface ll_mac_bridge_if #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned CNT_WIDTH  = 16
);

  // MAC -> bridge (RX)
  logic [DATA_WIDTH-1:0] mac_rx_data;
  logic                  mac_rx_valid;
  logic                  mac_rx_error;
  // bridge -> controller (RX LocalLink)
  logic [DATA_WIDTH-1:0] rx_ll_data;
  logic                  rx_ll_sof_n;
  logic                  rx_ll_eof_n;
  logic                  rx_ll_src_rdy_n;
  // controller -> bridge (TX LocalLink)
  logic [DATA_WIDTH-1:0] tx_ll_data;
  logic                  tx_ll_sof_n;
  logic                  tx_ll_eof_n;
  logic                  tx_ll_src_rdy_n;
  logic                  tx_ll_dst_rdy_n;
  // bridge -> MAC (TX)
  logic [DATA_WIDTH-1:0] mac_tx_data;
  logic                  mac_tx_en;
  logic                  mac_tx_error;
  // statistics
  logic [CNT_WIDTH-1:0]  rx_frame_count;
  logic [CNT_WIDTH-1:0]  rx_drop_count;
  logic [CNT_WIDTH-1:0]  tx_frame_count;

  modport master (
    input  mac_rx_data, mac_rx_valid, mac_rx_error,
    output rx_ll_data, rx_ll_sof_n, rx_ll_eof_n, rx_ll_src_rdy_n,
    input  tx_ll_data, tx_ll_sof_n, tx_ll_eof_n, tx_ll_src_rdy_n,
    output tx_ll_dst_rdy_n,
    output mac_tx_data, mac_tx_en, mac_tx_error,
    output rx_frame_count, rx_drop_count, tx_frame_count
  );

  modport slave (
    output mac_rx_data, mac_rx_valid, mac_rx_error,
    input  rx_ll_data, rx_ll_sof_n, rx_ll_eof_n, rx_ll_src_rdy_n,
    output tx_ll_data, tx_ll_sof_n, tx_ll_eof_n, tx_ll_src_rdy_n,
    input  tx_ll_dst_rdy_n,
    input  mac_tx_data, mac_tx_en, mac_tx_error,
    input  rx_frame_count, rx_drop_count, tx_frame_count
  );

endinterface

// File: rtl/ll_pipe_delay.sv
// Register chain of Depth stages, Width bits wide, with synchronous active-high reset.
// Depth 0 is a combinational pass-through.
// Ports:
//   clk_i  clock
//   rst_i  synchronous reset, loads ResetVal into every stage
//   d_i    input word
//   q_o    input word delayed by Depth cycles
module ll_pipe_delay #(
  parameter int unsigned     Width    = 8,
  parameter int unsigned     Depth    = 1,
  parameter logic [Width-1:0] ResetVal = '0
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [Width-1:0] d_i,
  output logic [Width-1:0] q_o
);

  if (Depth == 0) begin : g_bypass
    logic unused_clk_rst;
    assign unused_clk_rst = clk_i ^ rst_i;
    assign q_o = d_i;
  end else begin : g_chain
    logic [Width-1:0] stage_q [Depth];

    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        for (int i = 0; i < Depth; i++) stage_q[i] <= ResetVal;
      end else begin
        stage_q[0] <= d_i;
        for (int i = 1; i < Depth; i++) stage_q[i] <= stage_q[i-1];
      end
    end

    assign q_o = stage_q[Depth-1];
  end

endmodule

// File: rtl/ll_mac_bridge.sv
// Bridge between a valid/error strobed MAC beat stream and an active-low LocalLink port.
// RX: MAC beats are held one cycle so the true last beat can carry EOF; errored or oversize
//     frames are truncated (EOF on the last good beat) or dropped entirely, then the rest of
//     the frame is discarded. Output goes through RX_PIPE_STAGES extra register stages.
// TX: LocalLink beats are forwarded to the MAC one cycle after acceptance; after each frame
//     (or an underrun) dst_rdy_n is held high for IFG_CYCLES cycles.
// Ports:
//   clock  sole clock
//   reset  synchronous, active-high
//   bus    ll_mac_bridge_if.master: MAC RX/TX, LocalLink RX/TX, statistics counters
module ll_mac_bridge
  import ll_mac_bridge_pkg::*;
#(
  parameter int unsigned DATA_WIDTH      = 8,
  parameter int unsigned RX_PIPE_STAGES  = 1,
  parameter int unsigned IFG_CYCLES      = 4,
  parameter int unsigned MAX_FRAME_BEATS = 1518,
  parameter int unsigned CNT_WIDTH       = 16
) (
  input logic             clock,
  input logic             reset,
  ll_mac_bridge_if.master bus
);

  localparam int unsigned       BeatW    = $clog2(MAX_FRAME_BEATS + 2);
  localparam logic [BeatW-1:0]  MaxBeats = BeatW'(MAX_FRAME_BEATS);
  localparam logic [7:0]        IfgLoad  = 8'(IFG_CYCLES);
  localparam int unsigned       PipeW    = DATA_WIDTH + 3;

  // ---------------------------------------------------------------------------------------------
  // RX path
  // ---------------------------------------------------------------------------------------------
  rx_state_e             rx_state_q;
  logic [DATA_WIDTH-1:0] rx_hold_q;
  logic                  rx_first_q;     // held beat is the frame's first, nothing emitted yet
  logic [BeatW-1:0]      rx_beats_q;     // beats of this frame taken in, including the held one
  logic [DATA_WIDTH-1:0] rx_out_data_q;
  logic                  rx_out_sof_n_q;
  logic                  rx_out_eof_n_q;
  logic                  rx_out_src_rdy_n_q;
  logic [CNT_WIDTH-1:0]  rx_frame_cnt_q;
  logic [CNT_WIDTH-1:0]  rx_drop_cnt_q;
  logic                  rx_bad_beat;

  // Another beat would exceed the frame limit, or the MAC flags this beat.
  assign rx_bad_beat = bus.mac_rx_error || (rx_beats_q >= MaxBeats);

  always_ff @(posedge clock) begin
    if (reset) begin
      rx_state_q         <= RxIdle;
      rx_hold_q          <= '0;
      rx_first_q         <= 1'b0;
      rx_beats_q         <= '0;
      rx_out_data_q      <= '0;
      rx_out_sof_n_q     <= LlDeassert;
      rx_out_eof_n_q     <= LlDeassert;
      rx_out_src_rdy_n_q <= LlDeassert;
      rx_frame_cnt_q     <= '0;
      rx_drop_cnt_q      <= '0;
    end else begin
      rx_out_sof_n_q     <= LlDeassert;
      rx_out_eof_n_q     <= LlDeassert;
      rx_out_src_rdy_n_q <= LlDeassert;
      unique case (rx_state_q)
        RxIdle: begin
          if (bus.mac_rx_valid) begin
            if (bus.mac_rx_error) begin
              rx_drop_cnt_q <= CNT_WIDTH'(sat_inc(32'(rx_drop_cnt_q), CNT_WIDTH));
              rx_state_q    <= RxDiscard;
            end else begin
              rx_hold_q  <= bus.mac_rx_data;
              rx_first_q <= 1'b1;
              rx_beats_q <= BeatW'(1);
              rx_state_q <= RxRecv;
            end
          end
        end
        RxRecv: begin
          if (bus.mac_rx_valid && rx_bad_beat) begin
            // Close the frame on the held beat only if the controller has already seen a SOF.
            if (!rx_first_q) begin
              rx_out_data_q      <= rx_hold_q;
              rx_out_eof_n_q     <= LlAssert;
              rx_out_src_rdy_n_q <= LlAssert;
            end
            rx_drop_cnt_q <= CNT_WIDTH'(sat_inc(32'(rx_drop_cnt_q), CNT_WIDTH));
            rx_state_q    <= RxDiscard;
          end else if (bus.mac_rx_valid) begin
            rx_out_data_q      <= rx_hold_q;
            rx_out_sof_n_q     <= rx_first_q ? LlAssert : LlDeassert;
            rx_out_src_rdy_n_q <= LlAssert;
            rx_first_q         <= 1'b0;
            rx_hold_q          <= bus.mac_rx_data;
            rx_beats_q         <= rx_beats_q + 1'b1;
          end else begin
            rx_out_data_q      <= rx_hold_q;
            rx_out_sof_n_q     <= rx_first_q ? LlAssert : LlDeassert;
            rx_out_eof_n_q     <= LlAssert;
            rx_out_src_rdy_n_q <= LlAssert;
            rx_first_q         <= 1'b0;
            rx_frame_cnt_q     <= CNT_WIDTH'(sat_inc(32'(rx_frame_cnt_q), CNT_WIDTH));
            rx_state_q         <= RxIdle;
          end
        end
        RxDiscard: begin
          if (!bus.mac_rx_valid) rx_state_q <= RxIdle;
        end
        default: rx_state_q <= RxIdle;
      endcase
    end
  end

  logic [PipeW-1:0] rx_pipe_d;
  logic [PipeW-1:0] rx_pipe_q;

  assign rx_pipe_d = {rx_out_data_q, rx_out_sof_n_q, rx_out_eof_n_q, rx_out_src_rdy_n_q};

  ll_pipe_delay #(
    .Width    (PipeW),
    .Depth    (RX_PIPE_STAGES),
    .ResetVal ({{DATA_WIDTH{1'b0}}, 3'b111})
  ) u_rx_pipe (
    .clk_i (clock),
    .rst_i (reset),
    .d_i   (rx_pipe_d),
    .q_o   (rx_pipe_q)
  );

  assign bus.rx_ll_data      = rx_pipe_q[PipeW-1:3];
  assign bus.rx_ll_sof_n     = rx_pipe_q[2];
  assign bus.rx_ll_eof_n     = rx_pipe_q[1];
  assign bus.rx_ll_src_rdy_n = rx_pipe_q[0];
  assign bus.rx_frame_count  = rx_frame_cnt_q;
  assign bus.rx_drop_count   = rx_drop_cnt_q;

  // ---------------------------------------------------------------------------------------------
  // TX path
  // ---------------------------------------------------------------------------------------------
  tx_state_e             tx_state_q;
  logic [7:0]            tx_gap_q;
  logic                  tx_dst_rdy_n_q;
  logic [DATA_WIDTH-1:0] tx_data_q;
  logic                  tx_en_q;
  logic                  tx_err_q;
  logic [CNT_WIDTH-1:0]  tx_frame_cnt_q;
  logic                  tx_accept;

  assign tx_accept = (bus.tx_ll_src_rdy_n == LlAssert) && (tx_dst_rdy_n_q == LlAssert);

  always_ff @(posedge clock) begin
    if (reset) begin
      tx_state_q     <= TxIdle;
      tx_gap_q       <= '0;
      tx_dst_rdy_n_q <= LlAssert;
      tx_data_q      <= '0;
      tx_en_q        <= 1'b0;
      tx_err_q       <= 1'b0;
      tx_frame_cnt_q <= '0;
    end else begin
      tx_en_q  <= 1'b0;
      tx_err_q <= 1'b0;
      unique case (tx_state_q)
        TxIdle: begin
          // Beats without SOF (e.g. the tail of an underrun frame) are swallowed here.
          if (tx_accept && (bus.tx_ll_sof_n == LlAssert)) begin
            tx_en_q   <= 1'b1;
            tx_data_q <= bus.tx_ll_data;
            if (bus.tx_ll_eof_n == LlAssert) begin
              tx_frame_cnt_q <= CNT_WIDTH'(sat_inc(32'(tx_frame_cnt_q), CNT_WIDTH));
              tx_gap_q       <= IfgLoad;
              tx_dst_rdy_n_q <= LlDeassert;
              tx_state_q     <= TxGap;
            end else begin
              tx_state_q <= TxFrame;
            end
          end
        end
        TxFrame: begin
          if (tx_accept) begin
            tx_en_q   <= 1'b1;
            tx_data_q <= bus.tx_ll_data;
            if (bus.tx_ll_eof_n == LlAssert) begin
              tx_frame_cnt_q <= CNT_WIDTH'(sat_inc(32'(tx_frame_cnt_q), CNT_WIDTH));
              tx_gap_q       <= IfgLoad;
              tx_dst_rdy_n_q <= LlDeassert;
              tx_state_q     <= TxGap;
            end
          end else begin
            // Source stalled mid-frame: the MAC cannot wait, so abort.
            tx_err_q       <= 1'b1;
            tx_gap_q       <= IfgLoad;
            tx_dst_rdy_n_q <= LlDeassert;
            tx_state_q     <= TxGap;
          end
        end
        TxGap: begin
          // Counter holds IFG..1 across the gap, giving exactly IFG_CYCLES not-ready cycles.
          if (tx_gap_q <= 8'd1) begin
            tx_dst_rdy_n_q <= LlAssert;
            tx_state_q     <= TxIdle;
          end else begin
            tx_gap_q <= tx_gap_q - 8'd1;
          end
        end
        default: tx_state_q <= TxIdle;
      endcase
    end
  end

  assign bus.tx_ll_dst_rdy_n = tx_dst_rdy_n_q;
  assign bus.mac_tx_data     = tx_data_q;
  assign bus.mac_tx_en       = tx_en_q;
  assign bus.mac_tx_error    = tx_err_q;
  assign bus.tx_frame_count  = tx_frame_cnt_q;

endmodule

// File: tb/tb_ll_mac_bridge.sv
module tb_ll_mac_bridge;

  localparam int unsigned DW   = 8;
  localparam int unsigned PIPE = 1;
  localparam int unsigned IFG  = 4;
  localparam int unsigned MAXB = 1518;
  localparam int unsigned CW   = 16;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  ll_mac_bridge_if #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) bus ();

  ll_mac_bridge #(
    .DATA_WIDTH      (DW),
    .RX_PIPE_STAGES  (PIPE),
    .IFG_CYCLES      (IFG),
    .MAX_FRAME_BEATS (MAXB),
    .CNT_WIDTH       (CW)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  // ---------------- monitors ----------------
  typedef struct {
    int         cyc;
    logic [7:0] data;
    logic       sof_n;
    logic       eof_n;
  } rx_beat_t;
  rx_beat_t rxq[$];
  always @(negedge clock)
    if (bus.rx_ll_src_rdy_n == 1'b0)
      rxq.push_back('{cyc, bus.rx_ll_data, bus.rx_ll_sof_n, bus.rx_ll_eof_n});

  typedef struct {
    int         cyc;
    logic [7:0] data;
    logic       err;
  } tx_beat_t;
  tx_beat_t txq[$];
  always @(negedge clock)
    if (bus.mac_tx_en || bus.mac_tx_error)
      txq.push_back('{cyc, bus.mac_tx_data, bus.mac_tx_error});

  // Lengths of completed dst_rdy_n-high runs.
  int gapq[$];
  int gap_run = 0;
  always @(negedge clock) begin
    if (bus.tx_ll_dst_rdy_n === 1'b1) gap_run <= gap_run + 1;
    else if (gap_run != 0) begin
      gapq.push_back(gap_run);
      gap_run <= 0;
    end
  end

  // ---------------- checking ----------------
  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- drivers ----------------
  task automatic rx_frame(input int len, input int err_beat, input logic [7:0] base,
                          output int t0);
    t0 = 0;
    for (int i = 0; i < len; i++) begin
      @(posedge clock); #1;
      bus.mac_rx_valid = 1'b1;
      bus.mac_rx_data  = base + 8'(i);
      bus.mac_rx_error = (i + 1 == err_beat);
      if (i == 0) t0 = cyc;
    end
    @(posedge clock); #1;
    bus.mac_rx_valid = 1'b0;
    bus.mac_rx_error = 1'b0;
    bus.mac_rx_data  = '0;
  endtask

  // Offer len beats; if hole_at != 0, src_rdy_n goes high for one cycle before beat hole_at.
  task automatic tx_send(input logic [7:0] base, input int len, input int hole_at);
    int  i = 0;
    int  guard = 0;
    bit  hole_done = 0;
    while (i < len && guard < 100) begin
      guard++;
      @(posedge clock); #1;
      if (hole_at != 0 && i == hole_at - 1 && !hole_done) begin
        bus.tx_ll_src_rdy_n = 1'b1;
        hole_done = 1;
      end else begin
        bus.tx_ll_src_rdy_n = 1'b0;
        bus.tx_ll_data      = base + 8'(i);
        bus.tx_ll_sof_n     = (i != 0);
        bus.tx_ll_eof_n     = (i != len - 1);
        @(negedge clock);
        if (bus.tx_ll_dst_rdy_n == 1'b0) i++;
      end
    end
    chk("tx_send all beats accepted", i, len);
    @(posedge clock); #1;
    bus.tx_ll_src_rdy_n = 1'b1;
    bus.tx_ll_sof_n     = 1'b1;
    bus.tx_ll_eof_n     = 1'b1;
  endtask

  // ---------------- RX vector table ----------------
  typedef struct {
    int         len;
    int         err_beat;   // 1-based beat carrying mac_rx_error, 0 = none
    logic [7:0] base;
    int         exp_beats;
    int         d_frames;
    int         d_drops;
    bit         timing;
  } rx_vec_t;
  rx_vec_t vecs[7];

  int t0, f0, d0, n, errs;
  bit ok_data, ok_frm;
  logic [9:0] bb_exp[4];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{64,       0,  8'h00, 64,   1, 0, 1};
    vecs[1] = '{1,        0,  8'hA5, 1,    1, 0, 0};
    vecs[2] = '{20,       10, 8'h40, 9,    0, 1, 0};
    vecs[3] = '{MAXB + 1, 0,  8'h00, MAXB, 0, 1, 0};
    vecs[4] = '{5,        1,  8'h10, 0,    0, 1, 0};
    vecs[5] = '{3,        2,  8'h20, 0,    0, 1, 0};
    vecs[6] = '{2,        0,  8'hC0, 2,    1, 0, 0};

    bus.mac_rx_valid    = 1'b0;
    bus.mac_rx_error    = 1'b0;
    bus.mac_rx_data     = '0;
    bus.tx_ll_src_rdy_n = 1'b1;
    bus.tx_ll_sof_n     = 1'b1;
    bus.tx_ll_eof_n     = 1'b1;
    bus.tx_ll_data      = '0;

    // Reset values
    repeat (2) @(posedge clock);
    @(negedge clock);
    chk("reset rx strobes {sof,eof,src}",
        {bus.rx_ll_sof_n, bus.rx_ll_eof_n, bus.rx_ll_src_rdy_n}, 3'b111);
    chk("reset rx_ll_data", bus.rx_ll_data, 0);
    chk("reset tx_ll_dst_rdy_n", bus.tx_ll_dst_rdy_n, 0);
    chk("reset mac_tx {en,error}", {bus.mac_tx_en, bus.mac_tx_error}, 0);
    chk("reset mac_tx_data", bus.mac_tx_data, 0);
    chk("reset counters", {bus.rx_frame_count, bus.rx_drop_count, bus.tx_frame_count}, 0);
    @(posedge clock); #1;
    reset = 1'b0;

    // RX table
    for (int v = 0; v < 7; v++) begin
      rxq.delete();
      f0 = bus.rx_frame_count;
      d0 = bus.rx_drop_count;
      rx_frame(vecs[v].len, vecs[v].err_beat, vecs[v].base, t0);
      repeat (6) @(posedge clock);
      @(negedge clock);
      n = rxq.size();
      chk($sformatf("rx vec%0d beat count", v), n, vecs[v].exp_beats);
      ok_data = 1;
      ok_frm  = 1;
      for (int k = 0; k < n && k < vecs[v].exp_beats; k++) begin
        if (rxq[k].data !== vecs[v].base + 8'(k)) ok_data = 0;
        if (rxq[k].sof_n !== (k != 0)) ok_frm = 0;
        if (rxq[k].eof_n !== (k != vecs[v].exp_beats - 1)) ok_frm = 0;
      end
      if (vecs[v].exp_beats > 0) begin
        chk($sformatf("rx vec%0d data ok", v), ok_data, 1);
        chk($sformatf("rx vec%0d sof/eof ok", v), ok_frm, 1);
      end
      chk($sformatf("rx vec%0d frame count delta", v), bus.rx_frame_count - CW'(f0),
          vecs[v].d_frames);
      chk($sformatf("rx vec%0d drop count delta", v), bus.rx_drop_count - CW'(d0),
          vecs[v].d_drops);
      if (vecs[v].timing && n == vecs[v].exp_beats) begin
        chk($sformatf("rx vec%0d sof cycle", v), rxq[0].cyc, t0 + 2 + PIPE);
        chk($sformatf("rx vec%0d eof cycle", v), rxq[n-1].cyc, t0 + vecs[v].len + 1 + PIPE);
        chk($sformatf("rx vec%0d contiguous", v), rxq[n-1].cyc - rxq[0].cyc, n - 1);
      end
    end

    // Back-to-back RX: 1-beat frame, one idle cycle, 3-beat frame
    bb_exp[0] = {8'hA5, 1'b0, 1'b0};
    bb_exp[1] = {8'h50, 1'b0, 1'b1};
    bb_exp[2] = {8'h51, 1'b1, 1'b1};
    bb_exp[3] = {8'h52, 1'b1, 1'b0};
    rxq.delete();
    f0 = bus.rx_frame_count;
    @(posedge clock); #1;
    bus.mac_rx_valid = 1'b1;
    bus.mac_rx_data  = 8'hA5;
    t0 = cyc;
    @(posedge clock); #1;
    bus.mac_rx_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clock); #1;
      bus.mac_rx_valid = 1'b1;
      bus.mac_rx_data  = 8'h50 + 8'(i);
    end
    @(posedge clock); #1;
    bus.mac_rx_valid = 1'b0;
    repeat (6) @(posedge clock);
    @(negedge clock);
    chk("b2b beat count", rxq.size(), 4);
    for (int k = 0; k < 4 && k < rxq.size(); k++)
      chk($sformatf("b2b beat%0d {data,sof_n,eof_n}", k),
          {rxq[k].data, rxq[k].sof_n, rxq[k].eof_n}, bb_exp[k]);
    if (rxq.size() == 4) begin
      chk("b2b first frame cycle", rxq[0].cyc, t0 + 2 + PIPE);
      chk("b2b second frame sof cycle", rxq[1].cyc, t0 + 4 + PIPE);
    end
    chk("b2b frame count delta", bus.rx_frame_count - CW'(f0), 2);

    // TX: two 16-beat frames offered back-to-back
    txq.delete();
    gapq.delete();
    tx_send(8'h00, 16, 0);
    tx_send(8'h80, 16, 0);
    repeat (8) @(posedge clock);
    @(negedge clock);
    chk("tx2 mac beats", txq.size(), 32);
    if (txq.size() == 32) begin
      ok_data = 1;
      for (int k = 0; k < 32; k++) begin
        if (txq[k].data !== ((k < 16) ? 8'(k) : 8'h80 + 8'(k - 16))) ok_data = 0;
        if (txq[k].err !== 1'b0) ok_data = 0;
      end
      chk("tx2 data ok", ok_data, 1);
      chk("tx2 frame1 contiguous", txq[15].cyc - txq[0].cyc, 15);
      chk("tx2 frame2 contiguous", txq[31].cyc - txq[16].cyc, 15);
      chk("tx2 idle >= IFG", (txq[16].cyc - txq[15].cyc - 1) >= IFG, 1);
    end
    chk("tx2 gap runs", gapq.size(), 2);
    if (gapq.size() == 2) begin
      chk("tx2 gap0 length", gapq[0], IFG);
      chk("tx2 gap1 length", gapq[1], IFG);
    end
    chk("tx2 tx_frame_count", bus.tx_frame_count, 2);

    // TX underrun at beat 5, then a normal 8-beat frame
    txq.delete();
    gapq.delete();
    tx_send(8'h20, 10, 5);
    tx_send(8'h60, 8, 0);
    repeat (8) @(posedge clock);
    @(negedge clock);
    chk("underrun mac entries", txq.size(), 13);
    errs = 0;
    for (int k = 0; k < txq.size(); k++) if (txq[k].err) errs++;
    chk("underrun error pulses", errs, 1);
    if (txq.size() == 13) begin
      ok_data = 1;
      for (int k = 0; k < 4; k++)
        if (txq[k].data !== 8'h20 + 8'(k) || txq[k].err) ok_data = 0;
      for (int k = 5; k < 13; k++)
        if (txq[k].data !== 8'h60 + 8'(k - 5) || txq[k].err) ok_data = 0;
      chk("underrun data ok", ok_data, 1);
      chk("underrun error flag position", txq[4].err, 1);
      chk("underrun error right after beat 4", txq[4].cyc - txq[3].cyc, 1);
      chk("underrun next frame contiguous", txq[12].cyc - txq[5].cyc, 7);
    end
    chk("underrun gap runs", gapq.size(), 2);
    if (gapq.size() >= 1) chk("underrun gap length", gapq[0], IFG);
    chk("underrun tx_frame_count", bus.tx_frame_count, 3);

    // Reset mid-RX and mid-TX
    for (int i = 0; i < 5; i++) begin
      @(posedge clock); #1;
      bus.mac_rx_valid    = 1'b1;
      bus.mac_rx_data     = 8'h70 + 8'(i);
      bus.tx_ll_src_rdy_n = 1'b0;
      bus.tx_ll_sof_n     = (i != 0);
      bus.tx_ll_eof_n     = 1'b1;
      bus.tx_ll_data      = 8'h90 + 8'(i);
    end
    @(posedge clock); #1;
    reset = 1'b1;
    @(negedge clock);
    chk("midreset rx src active before reset", bus.rx_ll_src_rdy_n, 0);
    chk("midreset tx en active before reset", bus.mac_tx_en, 1);
    @(negedge clock);
    chk("midreset rx strobes {sof,eof,src}",
        {bus.rx_ll_sof_n, bus.rx_ll_eof_n, bus.rx_ll_src_rdy_n}, 3'b111);
    chk("midreset rx_ll_data", bus.rx_ll_data, 0);
    chk("midreset tx_ll_dst_rdy_n", bus.tx_ll_dst_rdy_n, 0);
    chk("midreset mac_tx {en,error,data}",
        {bus.mac_tx_en, bus.mac_tx_error, bus.mac_tx_data}, 0);
    chk("midreset counters", {bus.rx_frame_count, bus.rx_drop_count, bus.tx_frame_count}, 0);
    rxq.delete();
    txq.delete();
    @(posedge clock); #1;
    reset = 1'b0;
    bus.mac_rx_valid    = 1'b0;
    bus.tx_ll_src_rdy_n = 1'b1;
    bus.tx_ll_sof_n     = 1'b1;
    repeat (8) @(posedge clock);
    @(negedge clock);
    chk("post-reset no stray rx beats", rxq.size(), 0);
    chk("post-reset no stray tx beats", txq.size(), 0);

    // First frames after reset
    rx_frame(4, 0, 8'h33, t0);
    repeat (6) @(posedge clock);
    @(negedge clock);
    chk("post-reset rx beats", rxq.size(), 4);
    if (rxq.size() == 4) begin
      chk("post-reset rx first", {rxq[0].data, rxq[0].sof_n, rxq[0].eof_n}, {8'h33, 2'b01});
      chk("post-reset rx last", {rxq[3].data, rxq[3].sof_n, rxq[3].eof_n}, {8'h36, 2'b10});
      chk("post-reset rx sof cycle", rxq[0].cyc, t0 + 2 + PIPE);
    end
    chk("post-reset rx_frame_count", bus.rx_frame_count, 1);
    tx_send(8'hE0, 3, 0);
    repeat (4) @(posedge clock);
    @(negedge clock);
    chk("post-reset tx beats", txq.size(), 3);
    chk("post-reset tx_frame_count", bus.tx_frame_count, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
